seg_scan_display: RTL and testbench

Parametrised successor to the two-digit minute display driver. Converts a selected binary value (live or alarm) to BCD with a sequential double-dabble engine. Drives NDIG multiplexed seven-segment digits through a shared segment bus with a scan prescaler. Adds per-digit decimal points, configurable polarity and alarm-edit blinking. Sits between the time/alarm counters and the board display pins.

---
 rtl/seg_pkg.sv | 43 ++++
 rtl/seg_scan_display_if.sv | 28 ++
 rtl/seg_scan_display_bin2bcd_seq.sv | 58 +++++
 rtl/seg_scan_display.sv | 170 +++++++++++++++++
 tb/tb_seg_scan_display.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared types, segment table and sizing helpers for the multiplexed
// seven-segment display driver.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } conv_state_t;

    // Segment patterns for decimal digits, bit order GFEDCBA (bit 0 = A).
    localparam logic [6:0] SEG_CODE [0:9] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] code;
        code = SEG_CODE[0];
        case (nibble)
            4'd0:    code = SEG_CODE[0];
            4'd1:    code = SEG_CODE[1];
            4'd2:    code = SEG_CODE[2];
            4'd3:    code = SEG_CODE[3];
            4'd4:    code = SEG_CODE[4];
            4'd5:    code = SEG_CODE[5];
            4'd6:    code = SEG_CODE[6];
            4'd7:    code = SEG_CODE[7];
            4'd8:    code = SEG_CODE[8];
            4'd9:    code = SEG_CODE[9];
            default: code = SEG_CODE[0];
        endcase
        return code;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Value inputs and display pin outputs of the scan display driver, bundled
// so the counter logic (master) and the driver (slave) share one port.
interface seg_scan_display_if #(
    parameter int NDIG  = 2,
    parameter int VAL_W = 6
);

    logic [VAL_W-1:0] val;
    logic [VAL_W-1:0] aval;
    logic             alarm;
    logic             blink_en;
    logic [NDIG-1:0]  dp_mask;
    logic [6:0]       seg;
    logic             dp;
    logic [NDIG-1:0]  dig_en;
    logic             busy;

    modport master (
        output val, aval, alarm, blink_en, dp_mask,
        input  seg, dp, dig_en, busy
    );

    modport slave (
        input  val, aval, alarm, blink_en, dp_mask,
        output seg, dp, dig_en, busy
    );

endinterface

// File: rtl/seg_scan_display_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift/add-3 step per cycle,
// VAL_W steps after a start pulse, done flags the final step.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int VAL_W = 6,
    parameter int NDIG  = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [VAL_W-1:0]   i_bin,
    output logic [NDIG*4-1:0]  o_bcd,
    output logic               o_done
);

    localparam int CNT_W = clog2_min1(VAL_W);
    localparam int BCD_W = NDIG * 4;

    logic [VAL_W-1:0] r_bin;
    logic [BCD_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_active;
    logic [BCD_W-1:0] w_adj;

    // Correct every BCD nibble that would overflow past 9 on the next shift.
    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_adj
            assign w_adj[gi*4 +: 4] = (r_acc[gi*4 +: 4] >= 4'd5) ?
                                      (r_acc[gi*4 +: 4] + 4'd3) :
                                      r_acc[gi*4 +: 4];
        end
    endgenerate

    assign o_done = r_active && (r_cnt == CNT_W'(VAL_W - 1));
    assign o_bcd  = r_acc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bin    <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_bin    <= i_bin;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            {r_acc, r_bin} <= {w_adj, r_bin} << 1;
            r_cnt          <= r_cnt + 1'b1;
            if (o_done) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment driver: converts the live or alarm value to BCD,
// scans NDIG digits over a shared segment bus, with decimal points and blink.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NDIG       = 2,
    parameter int VAL_W      = 6,
    parameter int MAX_VAL    = 59,
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_DIV  = 250,
    parameter int ACTIVE_LOW = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    seg_scan_display_if.slave io_disp
);

    localparam int   IDX_W = clog2_min1(NDIG);
    localparam int   PRE_W = clog2_min1(SCAN_DIV);
    localparam int   BLK_W = clog2_min1(BLINK_DIV);
    localparam logic INV   = (ACTIVE_LOW != 0);

    conv_state_t        r_state;
    conv_state_t        w_state_next;
    logic               w_start;
    logic               w_busy;
    logic               w_load;
    logic [VAL_W-1:0]   w_sel_val;
    logic [VAL_W-1:0]   r_src;
    logic [NDIG*4-1:0]  w_bcd;
    logic               w_done;
    logic [NDIG*4-1:0]  r_digits;

    logic [PRE_W-1:0]   r_presc;
    logic               w_tick;
    logic [IDX_W-1:0]   r_index;
    logic [BLK_W-1:0]   r_blink_cnt;
    logic               r_phase;
    logic               w_blink_act;

    logic [3:0]         w_digit_arr [NDIG];
    logic [NDIG-1:0]    w_onehot;
    logic [6:0]         w_seg_raw;
    logic               w_dp_raw;
    logic [6:0]         r_seg;
    logic               r_dp;
    logic [NDIG-1:0]    r_dig_en;

    assign w_sel_val = io_disp.alarm ? io_disp.aval : io_disp.val;

    bin2bcd_seq #(
        .VAL_W (VAL_W),
        .NDIG  (NDIG)
    ) u_bin2bcd (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (w_start),
        .i_bin   (w_sel_val),
        .o_bcd   (w_bcd),
        .o_done  (w_done)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_busy       = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_start      = 1'b1;
                w_state_next = ST_CONV;
            end
            ST_CONV: begin
                w_busy = 1'b1;
                if (w_done) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_load       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The display only ever changes here, so a half-finished conversion is never shown.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_src    <= '0;
            r_digits <= '0;
        end else begin
            if (w_start) begin
                r_src <= w_sel_val;
            end
            if (w_load) begin
                r_digits <= (32'(r_src) > 32'(MAX_VAL)) ? '0 : w_bcd;
            end
        end
    end

    assign w_tick      = (r_presc == PRE_W'(SCAN_DIV - 1));
    assign w_blink_act = io_disp.alarm & io_disp.blink_en;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc <= '0;
            r_index <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_index <= (r_index == IDX_W'(NDIG - 1)) ? '0 : r_index + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (!w_blink_act) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (w_tick) begin
            if (r_blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            assign w_digit_arr[gi] = r_digits[gi*4 +: 4];
            assign w_onehot[gi]    = (r_index == IDX_W'(gi));
        end
    endgenerate

    assign w_seg_raw = r_phase ? seg_decode(w_digit_arr[r_index]) : SEG_BLANK;
    assign w_dp_raw  = r_phase & io_disp.dp_mask[r_index];

    // Pin registers: polarity applied last so the internal view is always active-high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seg    <= {7{INV}};
            r_dp     <= INV;
            r_dig_en <= {NDIG{INV}};
        end else begin
            r_seg    <= w_seg_raw ^ {7{INV}};
            r_dp     <= w_dp_raw ^ INV;
            r_dig_en <= w_onehot ^ {NDIG{INV}};
        end
    end

    assign io_disp.seg    = r_seg;
    assign io_disp.dp     = r_dp;
    assign io_disp.dig_en = r_dig_en;
    assign io_disp.busy   = w_busy;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed checks of the scan display driver: a 2-digit active-high instance
// and a 3-digit active-low instance, both with fast scan and blink dividers.
`timescale 1ns/1ps
module tb_seg_scan_display;

    logic clk = 1'b0;
    logic rst_n_a = 1'b0;
    logic rst_n_b = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    seg_scan_display_if #(.NDIG(2), .VAL_W(6))  bus_a ();
    seg_scan_display_if #(.NDIG(3), .VAL_W(10)) bus_b ();

    seg_scan_display #(
        .NDIG(2), .VAL_W(6), .MAX_VAL(59),
        .SCAN_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(0)
    ) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n_a),
        .io_disp (bus_a)
    );

    seg_scan_display #(
        .NDIG(3), .VAL_W(10), .MAX_VAL(999),
        .SCAN_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(1)
    ) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n_b),
        .io_disp (bus_b)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic find_a(input logic [1:0] en, output logic [6:0] seg, output logic dp, output bit found);
        found = 1'b0;
        seg   = '0;
        dp    = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            step(1);
            if (bus_a.dig_en === en) begin
                found = 1'b1;
                seg   = bus_a.seg;
                dp    = bus_a.dp;
            end
        end
    endtask

    task automatic find_b(input logic [2:0] en, output logic [6:0] seg, output logic dp, output bit found);
        found = 1'b0;
        seg   = '0;
        dp    = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            step(1);
            if (bus_b.dig_en === en) begin
                found = 1'b1;
                seg   = bus_b.seg;
                dp    = bus_b.dp;
            end
        end
    endtask

    task automatic test_reset();
        logic [1:0] exp_en;
        bus_a.val = '0; bus_a.aval = '0; bus_a.alarm = 1'b0; bus_a.blink_en = 1'b0; bus_a.dp_mask = '0;
        bus_b.val = '0; bus_b.aval = '0; bus_b.alarm = 1'b0; bus_b.blink_en = 1'b0; bus_b.dp_mask = '0;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        step(3);
        tests_run++;
        if (bus_a.seg !== 7'b0000000 || bus_a.dp !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_a_seg: seg=%b dp=%b expected seg=0000000 dp=0", bus_a.seg, bus_a.dp);
        end
        tests_run++;
        if (bus_a.dig_en !== 2'b00 || bus_a.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_a_en: dig_en=%b busy=%b expected 00 / 0", bus_a.dig_en, bus_a.busy);
        end
        tests_run++;
        if (bus_b.seg !== 7'b1111111 || bus_b.dp !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_b_seg: seg=%b dp=%b expected seg=1111111 dp=1", bus_b.seg, bus_b.dp);
        end
        tests_run++;
        if (bus_b.dig_en !== 3'b111 || bus_b.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_b_en: dig_en=%b busy=%b expected 111 / 0", bus_b.dig_en, bus_b.busy);
        end
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            step(1);
            exp_en = (((j - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10;
            tests_run++;
            if (bus_a.dig_en !== exp_en || bus_a.seg !== 7'b0111111) begin
                tests_failed++;
                $display("FAIL reset_walk[%0d]: dig_en=%b seg=%b expected dig_en=%b seg=0111111",
                         j, bus_a.dig_en, bus_a.seg, exp_en);
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_val47();
        logic [6:0] s;
        logic       d;
        bit         f;
        int         hi;
        bit         seen_low;
        bit         done;
        bus_a.val = 6'd47;
        step(16);
        find_a(2'b01, s, d, f);
        tests_run++;
        if (!f || s !== 7'b0000111) begin
            tests_failed++;
            $display("FAIL val47_dig0: found=%0d seg=%b expected 0000111", f, s);
        end
        find_a(2'b10, s, d, f);
        tests_run++;
        if (!f || s !== 7'b1100110) begin
            tests_failed++;
            $display("FAIL val47_dig1: found=%0d seg=%b expected 1100110", f, s);
        end
        hi = 0; seen_low = 1'b0; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step(1);
            if (bus_a.busy === 1'b0) begin
                if (hi > 0) done = 1'b1;
                seen_low = 1'b1;
            end else if (seen_low) begin
                hi++;
            end
        end
        tests_run++;
        if (!done || hi != 6) begin
            tests_failed++;
            $display("FAIL busy_len_a: complete=%0d high_cycles=%0d expected 6", done, hi);
        end
        $display("[TB] test_val47 done");
    endtask

    task automatic test_alarm_select();
        logic [6:0] s;
        logic       d;
        bit         f;
        bus_a.val   = 6'd12;
        bus_a.aval  = 6'd59;
        bus_a.alarm = 1'b1;
        step(20);
        find_a(2'b01, s, d, f);
        tests_run++;
        if (!f || s !== 7'b1101111) begin
            tests_failed++;
            $display("FAIL alarm_dig0: found=%0d seg=%b expected 1101111", f, s);
        end
        find_a(2'b10, s, d, f);
        tests_run++;
        if (!f || s !== 7'b1101101) begin
            tests_failed++;
            $display("FAIL alarm_dig1: found=%0d seg=%b expected 1101101", f, s);
        end
        bus_a.alarm = 1'b0;
        step(20);
        find_a(2'b01, s, d, f);
        tests_run++;
        if (!f || s !== 7'b1011011) begin
            tests_failed++;
            $display("FAIL live12_dig0: found=%0d seg=%b expected 1011011", f, s);
        end
        find_a(2'b10, s, d, f);
        tests_run++;
        if (!f || s !== 7'b0000110) begin
            tests_failed++;
            $display("FAIL live12_dig1: found=%0d seg=%b expected 0000110", f, s);
        end
        $display("[TB] test_alarm_select done");
    endtask

    task automatic test_range_limit();
        logic [6:0] s;
        logic       d;
        bit         f;
        bus_a.val = 6'd63;
        step(20);
        find_a(2'b01, s, d, f);
        tests_run++;
        if (!f || s !== 7'b0111111) begin
            tests_failed++;
            $display("FAIL over63_dig0: found=%0d seg=%b expected 0111111", f, s);
        end
        find_a(2'b10, s, d, f);
        tests_run++;
        if (!f || s !== 7'b0111111) begin
            tests_failed++;
            $display("FAIL over63_dig1: found=%0d seg=%b expected 0111111", f, s);
        end
        bus_a.val = 6'd59;
        step(20);
        find_a(2'b01, s, d, f);
        tests_run++;
        if (!f || s !== 7'b1101111) begin
            tests_failed++;
            $display("FAIL max59_dig0: found=%0d seg=%b expected 1101111", f, s);
        end
        find_a(2'b10, s, d, f);
        tests_run++;
        if (!f || s !== 7'b1101101) begin
            tests_failed++;
            $display("FAIL max59_dig1: found=%0d seg=%b expected 1101101", f, s);
        end
        $display("[TB] test_range_limit done");
    endtask

    task automatic test_blink();
        logic [1:0] prev;
        logic [1:0] exp_en;
        logic [6:0] exp_seg;
        logic       exp_dp;
        bit         on;
        bit         synced;
        bus_a.aval     = 6'd59;
        bus_a.alarm    = 1'b1;
        bus_a.blink_en = 1'b0;
        bus_a.dp_mask  = 2'b01;
        step(20);
        synced = 1'b0;
        prev   = bus_a.dig_en;
        for (int i = 0; i < 12 && !synced; i++) begin
            step(1);
            if (prev === 2'b01 && bus_a.dig_en === 2'b10) synced = 1'b1;
            prev = bus_a.dig_en;
        end
        tests_run++;
        if (!synced) begin
            tests_failed++;
            $display("FAIL blink_sync: dig_en=%b never stepped 01->10", bus_a.dig_en);
        end
        bus_a.blink_en = 1'b1;
        for (int j = 1; j <= 24; j++) begin
            step(1);
            on      = (j < 8) || (j >= 16 && j < 24);
            exp_en  = (j < 4) ? 2'b10 : ((((j - 4) / 4) % 2 == 0) ? 2'b01 : 2'b10);
            exp_seg = !on ? 7'b0000000 : ((exp_en == 2'b01) ? 7'b1101111 : 7'b1101101);
            exp_dp  = on && (exp_en == 2'b01);
            tests_run++;
            if (bus_a.dig_en !== exp_en || bus_a.seg !== exp_seg || bus_a.dp !== exp_dp) begin
                tests_failed++;
                $display("FAIL blink[%0d]: dig_en=%b seg=%b dp=%b expected dig_en=%b seg=%b dp=%b",
                         j, bus_a.dig_en, bus_a.seg, bus_a.dp, exp_en, exp_seg, exp_dp);
            end
        end
        bus_a.blink_en = 1'b0;
        step(2);
        tests_run++;
        if (bus_a.dig_en !== 2'b10 || bus_a.seg !== 7'b1101101 || bus_a.dp !== 1'b0) begin
            tests_failed++;
            $display("FAIL blink_off: dig_en=%b seg=%b dp=%b expected 10 / 1101101 / 0",
                     bus_a.dig_en, bus_a.seg, bus_a.dp);
        end
        $display("[TB] test_blink done");
    endtask

    task automatic test_active_low_3dig();
        logic [6:0] s;
        logic       d;
        bit         f;
        int         hi;
        bit         seen_low;
        bit         done;
        bus_b.val = 10'd908;
        step(30);
        find_b(3'b110, s, d, f);
        tests_run++;
        if (!f || s !== 7'b0000000 || d !== 1'b1) begin
            tests_failed++;
            $display("FAIL b908_dig0: found=%0d seg=%b dp=%b expected 0000000 / 1", f, s, d);
        end
        find_b(3'b101, s, d, f);
        tests_run++;
        if (!f || s !== 7'b1000000) begin
            tests_failed++;
            $display("FAIL b908_dig1: found=%0d seg=%b expected 1000000", f, s);
        end
        find_b(3'b011, s, d, f);
        tests_run++;
        if (!f || s !== 7'b0010000) begin
            tests_failed++;
            $display("FAIL b908_dig2: found=%0d seg=%b expected 0010000", f, s);
        end
        hi = 0; seen_low = 1'b0; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step(1);
            if (bus_b.busy === 1'b0) begin
                if (hi > 0) done = 1'b1;
                seen_low = 1'b1;
            end else if (seen_low) begin
                hi++;
            end
        end
        tests_run++;
        if (!done || hi != 10) begin
            tests_failed++;
            $display("FAIL busy_len_b: complete=%0d high_cycles=%0d expected 10", done, hi);
        end
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            step(1);
            if (bus_b.busy === 1'b1) done = 1'b1;
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL b_busy_wait: busy=%b expected 1 within 20 cycles", bus_b.busy);
        end
        step(3);
        #2;
        rst_n_b = 1'b0;
        #1;
        tests_run++;
        if (bus_b.seg !== 7'b1111111 || bus_b.dp !== 1'b1 || bus_b.dig_en !== 3'b111 || bus_b.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b_async_reset: seg=%b dp=%b dig_en=%b busy=%b expected 1111111 / 1 / 111 / 0",
                     bus_b.seg, bus_b.dp, bus_b.dig_en, bus_b.busy);
        end
        step(2);
        rst_n_b = 1'b1;
        step(1);
        tests_run++;
        if (bus_b.dig_en !== 3'b110 || bus_b.seg !== 7'b1000000) begin
            tests_failed++;
            $display("FAIL b_no_partial: dig_en=%b seg=%b expected 110 / 1000000", bus_b.dig_en, bus_b.seg);
        end
        step(30);
        find_b(3'b011, s, d, f);
        tests_run++;
        if (!f || s !== 7'b0010000) begin
            tests_failed++;
            $display("FAIL b_recover_dig2: found=%0d seg=%b expected 0010000", f, s);
        end
        $display("[TB] test_active_low_3dig done");
    endtask

    initial begin
        test_reset();
        test_val47();
        test_alarm_select();
        test_range_limit();
        test_blink();
        test_active_low_3dig();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
